// File: rtl/panda_pkg.sv
// panda_pkg: shared types for the panda M-extension unit.
//   md_operator_e : RV32M operator encoding (3 bits, RISC-V funct3 order)
//   md_state_e    : control state of the iterative multiply/divide unit
package panda_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_operator_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/panda_muldiv.sv
// panda_muldiv: iterative RV32M multiply/divide unit.
//   Shift-add multiplier and restoring divider share one Width+1-bit
//   adder/subtractor and one iteration counter. Operands are converted to
//   magnitudes at accept; the result sign is re-applied on the final step.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   operator_i              md_operator_e operator
//   operand_a_i/operand_b_i rs1 / rs2 values
//   valid_i / ready_o       request handshake (ready_o high only in IDLE)
//   kill_i                  aborts any in-flight operation or held result
//   result_o / valid_o      result handshake, held until ready_i
//   ready_i                 consumer accepts the result
//
// Build option:
//   PANDA_MULDIV_FAST_MUL_EN  multiply operators complete in one cycle with
//                             a combinational multiplier; divide stays
//                             iterative. Results are identical either way.
module panda_muldiv
  import panda_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  md_operator_e       operator_i,
  input  logic [Width-1:0]   operand_a_i,
  input  logic [Width-1:0]   operand_b_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               kill_i,
  output logic [Width-1:0]   result_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int CntW = $clog2(Width);

  // Re-apply the recorded sign and pick the architectural result.
  function automatic logic [Width-1:0] md_finalize(
    input md_operator_e     op,
    input logic             neg,
    input logic [Width-1:0] hi,
    input logic [Width-1:0] lo
  );
    logic [2*Width-1:0] prod;
    logic [Width-1:0]   res;
    prod = neg ? -{hi, lo} : {hi, lo};
    case (op)
      MD_MUL:                       res = prod[Width-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*Width-1:Width];
      MD_DIV, MD_DIVU:              res = neg ? -lo : lo;
      default:                      res = neg ? -hi : hi;
    endcase
    return res;
  endfunction

  function automatic logic [Width-1:0] md_magnitude(
    input logic [Width-1:0] v,
    input logic             neg
  );
    return neg ? -v : v;
  endfunction

  md_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  md_operator_e       op_q, op_d;
  logic               neg_q, neg_d;
  logic [Width-1:0]   hi_q, hi_d;
  logic [Width-1:0]   lo_q, lo_d;
  logic [Width-1:0]   b_q, b_d;
  logic [Width-1:0]   result_q, result_d;

  logic               accept;
  logic               op_is_div, op_is_rem, op_signed_div;
  logic               a_neg, b_neg;
  logic [Width-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [Width-1:0]   special_res;

  logic [Width:0]     add_a, add_b, add_res;
  logic               add_sub;
  logic               quot_bit;
  logic [Width-1:0]   iter_hi, iter_lo;

`ifdef PANDA_MULDIV_FAST_MUL_EN
  logic signed [Width:0]       fast_a, fast_b;
  logic signed [2*Width+1:0]   fast_p;
  logic [Width-1:0]            fast_res;
`endif

  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = (state_q == MD_DONE);
  assign result_o = result_q;
  assign accept   = valid_i & ready_o & ~kill_i;

  // Request decode and operand conditioning (only used on accept)
  always_comb begin
    op_is_div     = operator_i[2];
    op_is_rem     = (operator_i == MD_REM) || (operator_i == MD_REMU);
    op_signed_div = (operator_i == MD_DIV) || (operator_i == MD_REM);
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (operator_i)
      MD_MULH, MD_DIV, MD_REM: begin
        a_neg = operand_a_i[Width-1];
        b_neg = operand_b_i[Width-1];
      end
      MD_MULHSU: a_neg = operand_a_i[Width-1];
      default: ;
    endcase
    a_mag = md_magnitude(operand_a_i, a_neg);
    b_mag = md_magnitude(operand_b_i, b_neg);

    div_zero = op_is_div && (operand_b_i == '0);
    div_ovf  = op_signed_div &&
               (operand_a_i == {1'b1, {(Width-1){1'b0}}}) &&
               (operand_b_i == '1);
    if (div_zero)
      special_res = op_is_rem ? operand_a_i : '1;
    else
      special_res = op_is_rem ? '0 : operand_a_i;
  end

`ifdef PANDA_MULDIV_FAST_MUL_EN
  always_comb begin
    fast_a = $signed({(operator_i == MD_MULH || operator_i == MD_MULHSU) & operand_a_i[Width-1],
                      operand_a_i});
    fast_b = $signed({(operator_i == MD_MULH) & operand_b_i[Width-1], operand_b_i});
    fast_p = (2*Width+2)'(fast_a) * (2*Width+2)'(fast_b);
    fast_res = (operator_i == MD_MUL) ? fast_p[Width-1:0] : fast_p[2*Width-1:Width];
  end
`endif

  // One iteration on the shared adder/subtractor
  always_comb begin
    if (op_q[2]) begin
      add_a   = {hi_q, lo_q[Width-1]};
      add_b   = {1'b0, b_q};
      add_sub = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, b_q} : '0;
      add_sub = 1'b0;
    end
    add_res = add_a + (add_sub ? ~add_b : add_b) + {{Width{1'b0}}, add_sub};

    // Trial difference sign: shifted < divisor whenever it is negative, so
    // Width+1 bits hold it exactly and the dropped top bit is always zero.
    quot_bit = ~add_res[Width];
    if (op_q[2]) begin
      iter_hi = quot_bit ? add_res[Width-1:0] : add_a[Width-1:0];
      iter_lo = {lo_q[Width-2:0], quot_bit};
    end else begin
      iter_hi = add_res[Width:1];
      iter_lo = {add_res[0], lo_q[Width-1:1]};
    end
  end

  // Control: next state and register loads
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;

    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d  = operator_i;
          neg_d = op_is_rem ? a_neg : (a_neg ^ b_neg);
          hi_d  = '0;
          lo_d  = op_is_div ? a_mag : b_mag;
          b_d   = op_is_div ? b_mag : a_mag;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = MD_DONE;
`ifdef PANDA_MULDIV_FAST_MUL_EN
          end else if (!op_is_div) begin
            result_d = fast_res;
            state_d  = MD_DONE;
`endif
          end else begin
            cnt_d   = CntW'(Width - 1);
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        hi_d = iter_hi;
        lo_d = iter_lo;
        if (cnt_q == '0) begin
          result_d = md_finalize(op_q, neg_q, iter_hi, iter_lo);
          state_d  = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        if (ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    if (kill_i) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_panda_muldiv.sv
// tb_panda_muldiv: directed self-checking bench for panda_muldiv (Width=32).
module tb_panda_muldiv;
  import panda_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  md_operator_e operator_i;
  logic [31:0]  operand_a_i, operand_b_i;
  logic         valid_i, ready_o, kill_i;
  logic [31:0]  result_o;
  logic         valid_o, ready_i;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PANDA_MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  panda_muldiv #(.Width(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .kill_i      (kill_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Issue one request, scramble inputs after accept, wait for the result
  // (bounded) and complete the handshake with ready_i already high.
  task automatic run_op(input md_operator_e op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int n;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    valid_i     = 1'b1;
    @(posedge clk_i); #1;
    valid_i     = 1'b0;
    operator_i  = MD_REMU;
    operand_a_i = ~a;
    operand_b_i = b ^ 32'h5A5A_0F0F;
    lat = 0;
    res = '0;
    n   = 1;
    while (lat == 0 && n <= 100) begin
      if (valid_o) begin
        lat = n;
        res = result_o;
      end else begin
        @(posedge clk_i); #1;
        n++;
      end
    end
    if (lat != 0) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++;
    if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_o); end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat;
    run_op(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, r, lat);
    n_checks++;
    if (lat !== MulLat) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, MulLat); end
    n_checks++;
    if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", r); end
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat;
    run_op(MD_MULH, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++;
    if (r !== 32'h0000_0000) begin n_fail++; $display("FAIL mulh_result: got %h want 00000000", r); end
    run_op(MD_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++;
    if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL mulhu_result: got %h want 7fffffff", r); end
    run_op(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL mulhsu_result: got %h want 80000000", r); end
    n_checks++;
    if (lat !== MulLat) begin n_fail++; $display("FAIL mulhsu_latency: got %0d want %0d", lat, MulLat); end
    run_op(MD_MULH, 32'hFFFF_FFF9, 32'h0000_0003, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_neg_result: got %h want ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat;
    run_op(MD_DIV, 32'hFFFF_FFEC, 32'd3, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL div_result: got %h want fffffffa", r); end
    n_checks++;
    if (lat !== DivLat) begin n_fail++; $display("FAIL div_latency: got %0d want %0d", lat, DivLat); end
    run_op(MD_REM, 32'hFFFF_FFEC, 32'd3, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_result: got %h want fffffffe", r); end
    run_op(MD_DIVU, 32'd100, 32'd7, r, lat);
    n_checks++;
    if (r !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %h want 0000000e", r); end
    run_op(MD_REMU, 32'd100, 32'd7, r, lat);
    n_checks++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL remu_result: got %h want 00000002", r); end
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max_result: got %h want ffffffff", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat;
    run_op(MD_DIVU, 32'd5, 32'd0, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_result: got %h want ffffffff", r); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL divu0_latency: got %0d want 1", lat); end
    run_op(MD_REM, 32'd5, 32'd0, r, lat);
    n_checks++;
    if (r !== 32'd5) begin n_fail++; $display("FAIL rem0_result: got %h want 00000005", r); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL rem0_latency: got %0d want 1", lat); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_result: got %h want 80000000", r); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL divovf_latency: got %0d want 1", lat); end
    run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL removf_result: got %h want 00000000", r); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL removf_latency: got %0d want 1", lat); end
  endtask

  task automatic test_kill();
    logic seen;
    operator_i  = MD_DIV;
    operand_a_i = 32'd1000;
    operand_b_i = 32'd7;
    valid_i     = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk_i); #1;
    end
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL kill_ready: got %b want 1", ready_o); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_valid: got %b want 0", valid_o); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      seen |= valid_o;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL kill_no_result: valid_o seen %b want 0", seen); end
    // kill together with a request: not accepted
    operator_i  = MD_DIVU;
    operand_a_i = 32'd9;
    operand_b_i = 32'd0;
    valid_i = 1'b1;
    kill_i  = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_accept_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [31:0] r; int lat;
    operator_i  = MD_MUL;
    operand_a_i = 32'd12345;
    operand_b_i = 32'd678;
    valid_i     = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", ready_o); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid_o); end
    n_checks++;
    if (result_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", result_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      seen |= valid_o;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result: valid_o seen %b want 0", seen); end
    run_op(MD_MUL, 32'd12345, 32'd678, r, lat);
    n_checks++;
    if (r !== 32'd8369910) begin n_fail++; $display("FAIL rstmid_after_result: got %h want %h", r, 32'd8369910); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held, r;
    int lat, n;
    logic stable;
    ready_i     = 1'b0;
    operator_i  = MD_DIVU;
    operand_a_i = 32'd100;
    operand_b_i = 32'd7;
    valid_i     = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n <= 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b want 1", valid_o); end
    held   = result_o;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      operator_i  = MD_DIVU;
      operand_a_i = 32'd50 + i;
      operand_b_i = 32'd0;
      valid_i     = (i % 2 == 0);
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || result_o !== held) stable = 1'b0;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    n_checks++;
    if (held !== 32'd14) begin n_fail++; $display("FAIL bp_result: got %h want 0000000e", held); end
    n_checks++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: result/ready/valid not held (ready_o=%b valid_o=%b result_o=%h)", ready_o, valid_o, result_o); end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", valid_o); end
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", ready_o); end
    run_op(MD_REMU, 32'd100, 32'd7, r, lat);
    n_checks++;
    if (lat !== DivLat) begin n_fail++; $display("FAIL bp_next_latency: got %0d want %0d", lat, DivLat); end
    n_checks++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL bp_next_result: got %h want 00000002", r); end
  endtask

  initial begin
    rst_i       = 1'b1;
    operator_i  = MD_MUL;
    operand_a_i = '0;
    operand_b_i = '0;
    valid_i     = 1'b0;
    kill_i      = 1'b0;
    ready_i     = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    test_reset();
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_kill();
    test_reset_mid();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/panda_muldiv.md
Name: panda_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit implementing RV32M semantics, parametrised in Width.
- Sits beside the single-cycle ALU in the execute stage and serves all M-extension operators.
- Valid/ready on both sides, so the pipeline stalls while the unit is busy.
- Shift-add multiplier and restoring divider share one Width+1-bit adder/subtractor and one iteration counter.

Parameters:
- Width, 32, operand/result width in bits; must be even and >= 8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- operator_i  in  md_operator_e  MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
- operand_a_i  in  Width  rs1 value (multiplicand / dividend)
- operand_b_i  in  Width  rs2 value (multiplier / divisor)
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request
- kill_i  in  1  abort the in-flight operation (pipeline flush)
- result_o  out  Width  result
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high. Reset state: IDLE, ready_o=1, valid_o=0, result_o=0, counter=0, internal registers 0.
- States:
  - IDLE: ready_o=1. valid_i&ready_o in cycle T latches operator, operands and sign flags, then:
    - special case -> DONE at T+1;
    - otherwise -> CALC at T+1, counter=Width-1.
  - CALC: one iteration per cycle, counter decrements. When counter==0 the final iteration completes and the state moves to DONE. Normal latency is Width+1 cycles: accept at T, valid_o at T+Width+1.
  - DONE: valid_o=1 and result_o stays stable until valid_o&ready_i, then -> IDLE. ready_o=0, so no back-to-back accept from DONE.
- Operand conditioning at accept:
  - Signed operands (MULH: a,b; MULHSU: a only; DIV/REM: a,b) are converted to magnitude. The result sign is recorded: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Width+1-bit internal arithmetic ensures |-2^(Width-1)| is represented correctly.
- Multiply:
  - Each cycle, if the multiplier LSB is set, add the multiplicand into the upper accumulator half, then shift the 2*Width accumulator right by 1.
  - Final: two's-complement negate the 2*Width product if the sign flag is set.
  - MUL returns the low Width bits; MULH/MULHSU/MULHU return the high Width bits.
- Divide (restoring):
  - Each cycle, shift {rem,quot} left by 1 and trial-subtract the divisor from rem. If non-negative, keep the difference and set the quotient LSB.
  - Final: negate quotient/remainder per the recorded sign flags.
- Special cases, resolved at accept:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_a.
  - Signed overflow (a=-2^(Width-1), b=-1): DIV -> operand_a; REM -> 0.
- kill_i has priority over everything except reset. In any state it forces IDLE next cycle with valid_o=0, and any result in DONE is discarded. kill_i&valid_i in IDLE: the request is not accepted.
- Reset mid-operation: immediate return to the reset state; no partial result is ever visible.
- valid_o must not depend combinationally on ready_i. Inputs are sampled only at accept; later input changes have no effect.

Optional Feature:
- Macro: PANDA_MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply operators use a single-cycle Width+1 x Width+1 signed combinational multiplier: accept at T -> DONE with result at T+1.
  - Divide operators remain iterative.
- Undefined: all operators are iterative as above. Results are bit-identical in both builds; only latency differs.

Decomposition:
- panda_pkg:
  - md_operator_e enum, 3-bit, order as listed in Ports;
  - md_state_e {MD_IDLE, MD_CALC, MD_DONE}.
- Sub-module: none. A single module with the datapath and FSM is natural, as the iteration datapath is one shared adder and a separate block adds no reuse.

Test Plan (Width=32):
- MUL 0x0000_0007 x 0xFFFF_FFFD: valid_o at T+33, result_o 0xFFFF_FFEB.
- Multiply-high operators on a=0x8000_0000, b=0xFFFF_FFFF:
  - MULH -> 0x0000_0000;
  - MULHU -> 0x7FFF_FFFF;
  - MULHSU -> 0x8000_0000.
- DIV -20/3 -> 0xFFFF_FFFA (-6); REM -20/3 -> 0xFFFF_FFFE (-2); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, all with valid_o at T+1:
  - DIVU 5/0 -> 0xFFFF_FFFF;
  - REM 5/0 -> 5;
  - DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000;
  - REM of the same -> 0.
- Assert kill_i 10 cycles into a DIV -> next cycle IDLE, ready_o=1, valid_o never asserted. Assert rst_i mid-MUL -> outputs at reset values immediately.
- Hold ready_i=0 for 5 cycles in DONE -> result_o stable, ready_o=0, and valid_i pulses are ignored. Then ready_i=1 -> IDLE, and the next request is accepted the following cycle.
